// File: rtl/lsu_pkg.sv
// Shared core definitions: core FSM codes, LSU states
// and register-file input mux selects.
package lsu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

  localparam logic [1:0] RMUX_ARITHMETIC = 2'b00;
  localparam logic [1:0] RMUX_MEMORY     = 2'b01;
  localparam logic [1:0] RMUX_CONSTANT   = 2'b10;

endpackage

// File: rtl/lsu.sv
// Per-thread load/store unit: one FSM and element counter
// shared by the read and write memory channels.
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 8,
  parameter int Vector_Size = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [2:0]                     core_state,
  input  logic                           decoded_mem_read_enable,
  input  logic                           decoded_mem_write_enable,
  input  logic                           decoded_vector_mux,
  input  logic [DATA_BITS-1:0]           rs,
  input  logic [DATA_BITS-1:0]           rt,
  input  logic [DATA_BITS*Vector_Size-1:0] v_rt,
  output logic                           mem_read_valid,
  output logic [ADDR_BITS-1:0]           mem_read_address,
  input  logic                           mem_read_ready,
  input  logic [DATA_BITS-1:0]           mem_read_data,
  output logic                           mem_write_valid,
  output logic [ADDR_BITS-1:0]           mem_write_address,
  output logic [DATA_BITS-1:0]           mem_write_data,
  input  logic                           mem_write_ready,
  output logic [1:0]                     lsu_state,
  output logic [DATA_BITS-1:0]           lsu_out,
  output logic [Vector_Size*DATA_BITS-1:0] v_lsu_out
);

  localparam int CW = (Vector_Size > 1) ? $clog2(Vector_Size) : 1;
  localparam logic [CW-1:0] LAST = CW'(Vector_Size - 1);

  lsu_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_q, rd_d;
  logic vec_q, vec_d;
  logic rv_q, rv_d;
  logic wv_q, wv_d;
  logic [ADDR_BITS-1:0] raddr_q, raddr_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic [Vector_Size*DATA_BITS-1:0] vout_q, vout_d;
  logic [ADDR_BITS-1:0] addr;
  logic hs;

  // Next-state, request and capture logic; everything holds when disabled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    vec_d   = vec_q;
    rv_d    = rv_q;
    wv_d    = wv_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    vout_d  = vout_q;
    addr    = ADDR_BITS'(rs) + ADDR_BITS'(cnt_q);
    hs      = rd_q ? (rv_q & mem_read_ready)
                   : (wv_q & mem_write_ready);
    if (enable) begin
      unique case (state_q)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST &&
              (decoded_mem_read_enable ||
               decoded_mem_write_enable)) begin
            state_d = LSU_REQUESTING;
            cnt_d   = '0;
            rd_d    = decoded_mem_read_enable;
            vec_d   = decoded_vector_mux;
          end
        end
        LSU_REQUESTING: begin
          if (rd_q) begin
            rv_d    = 1'b1;
            raddr_d = addr;
          end else begin
            wv_d    = 1'b1;
            waddr_d = addr;
            wdata_d = vec_q
              ? v_rt[cnt_q*DATA_BITS +: DATA_BITS]
              : rt;
          end
          state_d = LSU_WAITING;
        end
        LSU_WAITING: begin
          if (hs) begin
            if (rd_q) begin
              if (vec_q)
                vout_d[cnt_q*DATA_BITS +: DATA_BITS] =
                  mem_read_data;
              else
                out_d = mem_read_data;
            end
            rv_d = 1'b0;
            wv_d = 1'b0;
            if (!vec_q || cnt_q == LAST) begin
              state_d = LSU_DONE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = LSU_REQUESTING;
            end
          end
        end
        LSU_DONE: begin
          if (core_state == CORE_UPDATE)
            state_d = LSU_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      vec_q   <= 1'b0;
      rv_q    <= 1'b0;
      wv_q    <= 1'b0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      out_q   <= '0;
      vout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      vec_q   <= vec_d;
      rv_q    <= rv_d;
      wv_q    <= wv_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
      vout_q  <= vout_d;
    end
  end

  assign mem_read_valid    = rv_q;
  assign mem_read_address  = raddr_q;
  assign mem_write_valid   = wv_q;
  assign mem_write_address = waddr_q;
  assign mem_write_data    = wdata_q;
  assign lsu_state         = state_q;
  assign lsu_out           = out_q;
  assign v_lsu_out         = vout_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random loads/stores
// against a transaction-level memory model.
module tb_lsu;

  localparam int VS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  core_state;
  logic        re, we, vm;
  logic [7:0]  rs, rt;
  logic [31:0] v_rt;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [7:0]  mem_read_data;
  logic        mem_write_valid;
  logic [7:0]  mem_write_address;
  logic [7:0]  mem_write_data;
  logic        mem_write_ready;
  logic [1:0]  lsu_state;
  logic [7:0]  lsu_out;
  logic [31:0] v_lsu_out;

  logic [7:0]  mem [256];
  logic [7:0]  exp_out;
  logic [31:0] exp_vout;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_read_address];

  lsu #(.DATA_BITS(8), .ADDR_BITS(8), .Vector_Size(VS)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .core_state(core_state),
    .decoded_mem_read_enable(re),
    .decoded_mem_write_enable(we),
    .decoded_vector_mux(vm),
    .rs(rs),
    .rt(rt),
    .v_rt(v_rt),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state),
    .lsu_out(lsu_out),
    .v_lsu_out(v_lsu_out)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One full REQUEST..UPDATE transaction. Ready rises after
  // valid has been high for d cycles. Cycle 1 is REQUESTING.
  task automatic run_op(input bit rd, input bit wr,
                        input bit vec,
                        input logic [7:0] base,
                        input logic [7:0] sdat,
                        input logic [31:0] vdat,
                        input int d);
    int e, k, seen, done_cyc;
    logic [7:0] ea, ed;
    logic act, rdy;
    e = vec ? VS : 1;
    k = 0;
    seen = 0;
    done_cyc = 0;
    @(negedge clk);
    core_state = 3'b011;
    re = rd; we = wr; vm = vec;
    rs = base; rt = sdat; v_rt = vdat;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
      @(negedge clk);
      core_state = 3'b100;
      if (lsu_state == 2'd3) begin
        done_cyc = c;
      end else begin
        ea = base + 8'(k);
        ed = (k < e) ? (vec ? vdat[k*8 +: 8] : sdat) : 8'hxx;
        if (rd) check("idle_wvalid", mem_write_valid, 0);
        else    check("idle_rvalid", mem_read_valid, 0);
        act = rd ? mem_read_valid : mem_write_valid;
        rdy = rd ? mem_read_ready : mem_write_ready;
        if (act) begin
          if (rd) begin
            check("rd_addr", mem_read_address, ea);
          end else begin
            check("wr_addr", mem_write_address, ea);
            check("wr_data", mem_write_data, ed);
          end
          if (!rdy) begin
            seen++;
            rdy = (seen >= d + 1);
          end
          if (rdy) begin
            if (rd) begin
              if (vec) exp_vout[k*8 +: 8] = mem[ea];
              else     exp_out = mem[ea];
            end
            k++;
          end
        end else begin
          rdy = 1'b0;
          seen = 0;
        end
        if (rd) mem_read_ready = rdy;
        else    mem_write_ready = rdy;
      end
    end
    check("done_cycle", done_cyc, 1 + e * (2 + d));
    check("beats", k, e);
    check("lsu_out", lsu_out, exp_out);
    check("v_lsu_out", v_lsu_out, exp_vout);
    core_state = 3'b110;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    @(negedge clk);
    check("back_idle", lsu_state, 0);
    check("valids_low", {mem_read_valid, mem_write_valid}, 0);
    core_state = 3'b000;
    re = 1'b0; we = 1'b0; vm = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    core_state = 3'b000;
    re = 1'b0; we = 1'b0; vm = 1'b0;
    rs = 8'h00; rt = 8'h00; v_rt = 32'h0;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    exp_out = 8'h00;
    exp_vout = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 1);
    mem[8'h10] = 8'hA5;

    repeat (2) @(negedge clk);
    check("rst_state", lsu_state, 0);
    check("rst_rd", {mem_read_valid, mem_read_address}, 0);
    check("rst_wr", {mem_write_valid, mem_write_address,
                     mem_write_data}, 0);
    check("rst_data", {lsu_out, v_lsu_out}, 0);
    reset = 1'b1;

    // Ready with no valid and no enables must do nothing.
    core_state = 3'b011;
    mem_read_ready = 1'b1;
    mem_write_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("quiet_state", lsu_state, 0);
    check("quiet_outs", {mem_read_valid, mem_write_valid,
                         lsu_out, v_lsu_out}, 0);
    core_state = 3'b000;

    // 1: scalar load
    run_op(1, 0, 0, 8'h10, 8'h00, 32'h0, 0);
    check("ld_lit", lsu_out, 8'hA5);
    // 2: scalar store, ready late
    run_op(0, 1, 0, 8'h20, 8'h3C, 32'h0, 3);
    check("st_keeps_out", lsu_out, 8'hA5);

    // 5: asynchronous reset while a read waits
    @(negedge clk);
    core_state = 3'b011;
    re = 1'b1; vm = 1'b0; rs = 8'h33;
    @(negedge clk);
    core_state = 3'b100;
    @(posedge clk);
    #2;
    check("pre_rst_valid", mem_read_valid, 1);
    reset = 1'b0;
    #1;
    check("arst_valid", mem_read_valid, 0);
    check("arst_state", lsu_state, 0);
    check("arst_data", {lsu_out, v_lsu_out, mem_read_address}, 0);
    exp_out = 8'h00;
    exp_vout = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    re = 1'b0;
    core_state = 3'b000;
    repeat (3) @(negedge clk);
    check("post_rst_quiet", {lsu_state, mem_read_valid,
                             mem_write_valid, lsu_out}, 0);

    // 3: vector load
    run_op(1, 0, 1, 8'h40, 8'h00, 32'h0, 0);
    check("vld_lit", v_lsu_out, 32'h44434241);
    // 4: vector store wrapping past 0xFF
    run_op(0, 1, 1, 8'hFE, 8'h00, 32'hDDCCBBAA, 0);
    check("vst_keeps", v_lsu_out, 32'h44434241);

    // 6: both enables, then a freeze while waiting
    mem[8'h55] = 8'h5A;
    @(negedge clk);
    core_state = 3'b011;
    re = 1'b1; we = 1'b1; vm = 1'b0; rs = 8'h55;
    @(negedge clk);
    core_state = 3'b100;
    @(negedge clk);
    check("frz_pre_state", lsu_state, 2);
    check("frz_pre_valid", {mem_read_valid, mem_write_valid}, 2'b10);
    enable = 1'b0;
    mem_read_ready = 1'b1;
    mem_write_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("frz_state", lsu_state, 2);
      check("frz_valid", {mem_read_valid, mem_write_valid}, 2'b10);
      check("frz_addr", mem_read_address, 8'h55);
      check("frz_out", lsu_out, exp_out);
    end
    enable = 1'b1;
    @(negedge clk);
    check("thaw_done", lsu_state, 3);
    check("thaw_out", lsu_out, 8'h5A);
    check("thaw_wr", mem_write_valid, 0);
    exp_out = 8'h5A;
    core_state = 3'b110;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    @(negedge clk);
    check("thaw_idle", lsu_state, 0);
    core_state = 3'b000;
    re = 1'b0; we = 1'b0;

    // Both enables through the generic path, vector this time.
    run_op(1, 1, 1, 8'h80, 8'h00, 32'h0, 1);

    // Random transactions over random memory contents.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 12; t++) begin
      bit rd, wr, vec;
      rd  = 1'($urandom);
      wr  = rd ? 1'($urandom) : 1'b1;
      vec = 1'($urandom);
      run_op(rd, wr, vec, 8'($urandom), 8'($urandom),
             $urandom, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
